// File: rtl/pe_msg_feeder.sv
// pe_msg_feeder: transmit side of the PE edge interface.
// For each job it sends one weight message, then LEN activation beats, where
// every beat pairs an activation message with a part_prod seed. Each output
// channel is a registered val/rdy pair that holds its value and data until it fires.

module pe_msg_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int MAX_LEN   = 8,
  localparam int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,

  input  logic [BIT_WIDTH-1:0] i_job_weight,
  input  logic [BIT_WIDTH-1:0] i_job_seed,
  input  logic [LW-1:0]        i_job_len,
  input  logic                 i_job_val,
  output logic                 o_job_rdy,

  input  logic [BIT_WIDTH-1:0] i_act,
  input  logic                 i_act_val,
  output logic                 o_act_rdy,

  output logic [BIT_WIDTH:0]   o_msg_send,
  output logic                 o_msg_send_val,
  input  logic                 i_msg_send_rdy,

  output logic [BIT_WIDTH-1:0] o_part_prod_send,
  output logic                 o_part_prod_send_val,
  input  logic                 i_part_prod_send_rdy,

  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND_W,
    STREAM
  } state_e;

  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE     = LW'(1);

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] seed_q, seed_d;
  logic [LW-1:0]        len_q, len_d;
  logic [LW-1:0]        loaded_q, loaded_d;
  logic [LW-1:0]        sent_q, sent_d;
  logic [BIT_WIDTH:0]   msgData_q, msgData_d;
  logic                 msgVal_q, msgVal_d;
  logic [BIT_WIDTH-1:0] ppData_q, ppData_d;
  logic                 ppVal_q, ppVal_d;
  logic                 done_q, done_d;

  logic                 msgFire;
  logic                 ppFire;
  logic                 beatPending;
  logic                 beatDone;
  logic                 actRdy;
  logic                 actFire;
  logic                 lastBeat;
  logic [LW-1:0]        jobLenSat;

  // Handshake decode: a beat is complete once every channel still holding it fires.
  always_comb begin
    msgFire     = msgVal_q && i_msg_send_rdy;
    ppFire      = ppVal_q && i_part_prod_send_rdy;
    beatPending = (state_q == STREAM) && (msgVal_q || ppVal_q);
    beatDone    = beatPending && (!msgVal_q || msgFire) && (!ppVal_q || ppFire);
    actRdy      = (state_q == STREAM) && (loaded_q < len_q) && (!beatPending || beatDone);
    actFire     = actRdy && i_act_val;
    lastBeat    = beatDone && ((sent_q + ONE) == len_q);
    jobLenSat   = (i_job_len > LEN_MAX) ? LEN_MAX : i_job_len;
  end

  // Next-state logic for the job FSM and the two output channel registers.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    len_d     = len_q;
    loaded_d  = loaded_q;
    sent_d    = sent_q;
    msgData_d = msgData_q;
    msgVal_d  = msgVal_q;
    ppData_d  = ppData_q;
    ppVal_d   = ppVal_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_job_val) begin
          seed_d    = i_job_seed;
          len_d     = jobLenSat;
          loaded_d  = '0;
          sent_d    = '0;
          msgData_d = {1'b1, i_job_weight};
          msgVal_d  = 1'b1;
          state_d   = SEND_W;
        end
      end

      SEND_W: begin
        if (msgFire) begin
          msgVal_d = 1'b0;
          loaded_d = '0;
          sent_d   = '0;
          if (len_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end
      end

      STREAM: begin
        if (msgFire) begin
          msgVal_d = 1'b0;
        end
        if (ppFire) begin
          ppVal_d = 1'b0;
        end
        if (beatDone) begin
          sent_d = sent_q + ONE;
        end
        if (actFire) begin
          msgData_d = {1'b0, i_act};
          msgVal_d  = 1'b1;
          ppData_d  = seed_q;
          ppVal_d   = 1'b1;
          loaded_d  = loaded_q + ONE;
        end
        if (lastBeat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        msgVal_d = 1'b0;
        ppVal_d  = 1'b0;
      end
    endcase
  end

  // State and channel registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      len_q     <= '0;
      loaded_q  <= '0;
      sent_q    <= '0;
      msgData_q <= '0;
      msgVal_q  <= 1'b0;
      ppData_q  <= '0;
      ppVal_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      len_q     <= len_d;
      loaded_q  <= loaded_d;
      sent_q    <= sent_d;
      msgData_q <= msgData_d;
      msgVal_q  <= msgVal_d;
      ppData_q  <= ppData_d;
      ppVal_q   <= ppVal_d;
      done_q    <= done_d;
    end
  end

  assign o_job_rdy            = (state_q == IDLE);
  assign o_busy               = (state_q != IDLE);
  assign o_done               = done_q;
  assign o_act_rdy            = actRdy;
  assign o_msg_send           = msgData_q;
  assign o_msg_send_val       = msgVal_q;
  assign o_part_prod_send     = ppData_q;
  assign o_part_prod_send_val = ppVal_q;

endmodule

// File: tb/tb_pe_msg_feeder.sv
// tb_pe_msg_feeder: scoreboard bench for pe_msg_feeder.
// Stimulus pushes expected msg / part_prod values as it issues jobs and
// activations; a negedge monitor pops and compares on every channel fire.

module tb_pe_msg_feeder;

  logic       clk;
  logic       rstN;
  logic [7:0] jobWeight;
  logic [7:0] jobSeed;
  logic [3:0] jobLen;
  logic       jobVal;
  logic       jobRdy;
  logic [7:0] act;
  logic       actVal;
  logic       actRdy;
  logic [8:0] msgSend;
  logic       msgVal;
  logic       msgRdy;
  logic [7:0] pp;
  logic       ppVal;
  logic       ppRdy;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [8:0] msgQ[$];
  logic [7:0] ppQ[$];
  logic [7:0] actList[$];
  logic [7:0] curSeed;

  int cyc          = 0;
  int lastFireCyc  = 0;
  int doneSeen     = 0;
  int expDone      = 0;
  int actRdyCycles = 0;
  int ppFires      = 0;
  int ppValCycles  = 0;
  int firstPpCyc   = 0;
  int lastPpCyc    = 0;

  logic       prevRstN     = 1'b0;
  logic       prevMsgStall = 1'b0;
  logic       prevPpStall  = 1'b0;
  logic [8:0] prevMsg      = '0;
  logic [7:0] prevPp       = '0;

  pe_msg_feeder #(
    .BIT_WIDTH(8),
    .MAX_LEN(8)
  ) dut (
    .i_clk                (clk),
    .i_rst_n              (rstN),
    .i_job_weight         (jobWeight),
    .i_job_seed           (jobSeed),
    .i_job_len            (jobLen),
    .i_job_val            (jobVal),
    .o_job_rdy            (jobRdy),
    .i_act                (act),
    .i_act_val            (actVal),
    .o_act_rdy            (actRdy),
    .o_msg_send           (msgSend),
    .o_msg_send_val       (msgVal),
    .i_msg_send_rdy       (msgRdy),
    .o_part_prod_send     (pp),
    .o_part_prod_send_val (ppVal),
    .i_part_prod_send_rdy (ppRdy),
    .o_busy               (busy),
    .o_done               (done)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic failOutput(input string name, input logic [31:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h, expected no transfer", name, actual);
  endtask

  task automatic resetCounters();
    actRdyCycles = 0;
    ppFires      = 0;
    ppValCycles  = 0;
    firstPpCyc   = 0;
    lastPpCyc    = 0;
  endtask

  // Scoreboard monitor: compares fires against expected queues and checks hold/done rules.
  always @(negedge clk) begin
    cyc++;
    if (rstN) begin
      if (actRdy) actRdyCycles++;
      if (ppVal) ppValCycles++;
      if (msgVal && msgRdy) begin
        lastFireCyc = cyc;
        if (msgQ.size() == 0) failOutput("msgUnexpected", 32'(msgSend));
        else checkOutput("msgData", 32'(msgSend), 32'(msgQ.pop_front()));
      end
      if (ppVal && ppRdy) begin
        lastFireCyc = cyc;
        if (ppFires == 0) firstPpCyc = cyc;
        lastPpCyc = cyc;
        ppFires++;
        if (ppQ.size() == 0) failOutput("ppUnexpected", 32'(pp));
        else checkOutput("ppData", 32'(pp), 32'(ppQ.pop_front()));
      end
      if (done) begin
        doneSeen++;
        checkOutput("doneLatency", 32'(cyc - lastFireCyc), 32'd1);
        checkOutput("doneJobRdy", 32'(jobRdy), 32'd1);
      end
      if (prevRstN && prevMsgStall) begin
        checkOutput("msgValHold", 32'(msgVal), 32'd1);
        checkOutput("msgDataHold", 32'(msgSend), 32'(prevMsg));
      end
      if (prevRstN && prevPpStall) begin
        checkOutput("ppValHold", 32'(ppVal), 32'd1);
        checkOutput("ppDataHold", 32'(pp), 32'(prevPp));
      end
    end
    prevRstN     = rstN;
    prevMsgStall = msgVal && !msgRdy;
    prevPpStall  = ppVal && !ppRdy;
    prevMsg      = msgSend;
    prevPp       = pp;
  end

  task automatic sendJob(input logic [7:0] w, input logic [7:0] s, input logic [3:0] len);
    int n;
    logic seen;
    jobWeight = w;
    jobSeed   = s;
    jobLen    = len;
    jobVal    = 1'b1;
    curSeed   = s;
    msgQ.push_back({1'b1, w});
    expDone++;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = jobRdy;
      @(posedge clk);
      #1;
      n++;
    end
    jobVal = 1'b0;
    checkOutput("jobAccept", 32'(seen), 32'd1);
  endtask

  task automatic sendAct(input logic [7:0] a);
    int n;
    logic seen;
    act    = a;
    actVal = 1'b1;
    msgQ.push_back({1'b0, a});
    ppQ.push_back(curSeed);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = actRdy;
      @(posedge clk);
      #1;
      n++;
    end
    actVal = 1'b0;
    checkOutput("actAccept", 32'(seen), 32'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    checkOutput("idleReached", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic endTest(input string name);
    checkOutput({name, "_msgQEmpty"}, 32'(msgQ.size()), 32'd0);
    checkOutput({name, "_ppQEmpty"}, 32'(ppQ.size()), 32'd0);
    checkOutput({name, "_doneCount"}, 32'(doneSeen), 32'(expDone));
  endtask

  task automatic applyStimulus(input logic [7:0] w, input logic [7:0] s, input logic [3:0] len);
    sendJob(w, s, len);
    foreach (actList[i]) sendAct(actList[i]);
    actVal = 1'b1;
    actVal = 1'b0;
    waitIdle();
  endtask

  // Directed test sequence.
  initial begin
    rstN      = 1'b0;
    jobWeight = '0;
    jobSeed   = '0;
    jobLen    = '0;
    jobVal    = 1'b0;
    act       = '0;
    actVal    = 1'b0;
    msgRdy    = 1'b1;
    ppRdy     = 1'b1;
    curSeed   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_msgVal", 32'(msgVal), 32'd0);
    checkOutput("rst_ppVal", 32'(ppVal), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_jobRdy", 32'(jobRdy), 32'd1);
    checkOutput("rst_actRdy", 32'(actRdy), 32'd0);
    checkOutput("rst_msgSend", 32'(msgSend), 32'd0);
    checkOutput("rst_pp", 32'(pp), 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] T1 single beat");
    resetCounters();
    sendJob(8'd17, 8'd1, 4'd1);
    checkOutput("t1_wLatencyVal", 32'(msgVal), 32'd1);
    checkOutput("t1_wLatencyData", 32'(msgSend), 32'h111);
    checkOutput("t1_wNoPp", 32'(ppVal), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    sendAct(8'd13);
    waitIdle();
    checkOutput("t1_ppFires", 32'(ppFires), 32'd1);
    endTest("t1");

    $display("[TB] T2 back-to-back");
    resetCounters();
    actList = '{8'd0, 8'd5, 8'd8, 8'd12, 8'd13};
    applyStimulus(8'd3, 8'd0, 4'd5);
    checkOutput("t2_actRdyCycles", 32'(actRdyCycles), 32'd5);
    checkOutput("t2_ppFires", 32'(ppFires), 32'd5);
    checkOutput("t2_consecutive", 32'(lastPpCyc - firstPpCyc), 32'd4);
    endTest("t2");

    $display("[TB] T3 skewed ready");
    resetCounters();
    sendJob(8'd44, 8'd4, 4'd2);
    ppRdy = 1'b0;
    sendAct(8'd7);
    fork
      begin
        sendAct(8'd9);
      end
      begin
        @(negedge clk);
        checkOutput("t3_actRdyPending", 32'(actRdy), 32'd0);
        @(negedge clk);
        checkOutput("t3_msgDropped", 32'(msgVal), 32'd0);
        checkOutput("t3_ppHeld", 32'(ppVal), 32'd1);
        checkOutput("t3_ppDataHeld", 32'(pp), 32'd4);
        checkOutput("t3_actRdyHeld", 32'(actRdy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        ppRdy = 1'b1;
      end
    join
    waitIdle();
    checkOutput("t3_ppFires", 32'(ppFires), 32'd2);
    endTest("t3");

    $display("[TB] T4 len zero and saturation");
    resetCounters();
    actList = {};
    applyStimulus(8'd9, 8'd7, 4'd0);
    checkOutput("t4_noPpVal", 32'(ppValCycles), 32'd0);
    endTest("t4a");
    resetCounters();
    actList = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    applyStimulus(8'd50, 8'd2, 4'd12);
    checkOutput("t4_satBeats", 32'(ppFires), 32'd8);
    endTest("t4b");

    $display("[TB] T5 mid-job reset");
    resetCounters();
    sendJob(8'd2, 8'd3, 4'd4);
    sendAct(8'd20);
    sendAct(8'd21);
    sendAct(8'd22);
    msgRdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t5_msgVal", 32'(msgVal), 32'd0);
    checkOutput("t5_ppVal", 32'(ppVal), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_jobRdy", 32'(jobRdy), 32'd1);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_ppFiresBefore", 32'(ppFires), 32'd3);
    @(posedge clk);
    #1;
    rstN   = 1'b1;
    msgRdy = 1'b1;
    msgQ   = {};
    ppQ    = {};
    expDone--;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_noDoneAfterReset", 32'(doneSeen), 32'(expDone));
    resetCounters();
    actList = '{8'd10, 8'd11};
    applyStimulus(8'd5, 8'd6, 4'd2);
    checkOutput("t5_freshBeats", 32'(ppFires), 32'd2);
    endTest("t5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] time limit reached");
  end

endmodule
